// File: rtl/params.sv
// ---------------------------------------------------------------------------
// params -- shared timing constants and types for video_timing.
//
// Holds the default 640x480@60 raster geometry, derived line/frame totals,
// the per-axis phase enum, and the colour-bar helper used by the optional
// test pattern (VTIMING_PATTERN_EN).
// ---------------------------------------------------------------------------
package params;

    localparam int unsigned HRES   = 640;
    localparam int unsigned VRES   = 480;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    // 0 = active-low sync
    localparam logic HSYNC_POL = 1'b0;
    localparam logic VSYNC_POL = 1'b0;

    localparam int unsigned H_TOTAL = HRES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = VRES + V_FP + V_SYNC + V_BP;

    // Totals fit in 11 bits; the extra bit carries the sign for consumers.
    localparam int unsigned CNT_W = 12;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } phase_t;

    // Returns {R,G,B} enables for the colour bar covering pixel x.
    // Bars run white, yellow, cyan, green, magenta, red, blue, black, which
    // is exactly the complement of the bar index bits (B=~i[0], R=~i[1],
    // G=~i[2]). Pixels past the eighth bar (HRES not a multiple of 8) are
    // treated as black.
    function automatic logic [2:0] bar_bgr(input logic [CNT_W-1:0] x,
                                           input int unsigned       hres);
        int unsigned w;
        int unsigned idx;
        logic [2:0]  rgb;
        w   = (hres >= 8) ? hres / 8 : 1;
        idx = 32'(x) / w;
        if (idx > 7) begin
            idx = 7;
        end
        rgb[0] = ~idx[0];
        rgb[1] = ~idx[2];
        rgb[2] = ~idx[1];
        return rgb;
    endfunction

endpackage

// File: rtl/vtg_axis.sv
// ---------------------------------------------------------------------------
// vtg_axis -- one raster axis: position counter plus ACTIVE/FP/SYNC/BP phase.
//
// Ports:
//   pixel_clk  in   clock
//   rst        in   synchronous active-high reset (count 0, phase ACTIVE)
//   advance    in   step the counter this cycle
//   count      out  registered position, 0 .. ACT+FP+SYNC+BP-1
//   phase      out  registered phase matching count
//   wrap       out  advance is set and count is at its last value
//   count_nxt  out  value count takes at the next edge (ignoring rst)
//   phase_nxt  out  value phase takes at the next edge (ignoring rst)
//
// The *_nxt outputs let the parent register derived signals so they stay
// cycle-aligned with count/phase.
// ---------------------------------------------------------------------------
module vtg_axis #(
    parameter int unsigned ACT  = params::HRES,
    parameter int unsigned FP   = params::H_FP,
    parameter int unsigned SYNC = params::H_SYNC,
    parameter int unsigned BP   = params::H_BP
) (
    input  logic                       pixel_clk,
    input  logic                       rst,
    input  logic                       advance,
    output logic [params::CNT_W-1:0]   count,
    output params::phase_t             phase,
    output logic                       wrap,
    output logic [params::CNT_W-1:0]   count_nxt,
    output params::phase_t             phase_nxt
);

    localparam int unsigned W = params::CNT_W;

    localparam logic [W-1:0] LAST       = W'(ACT + FP + SYNC + BP - 1);
    localparam logic [W-1:0] START_FP   = W'(ACT);
    localparam logic [W-1:0] START_SYNC = W'(ACT + FP);
    localparam logic [W-1:0] START_BP   = W'(ACT + FP + SYNC);

    always_comb begin
        wrap      = advance && (count == LAST);
        count_nxt = count;
        phase_nxt = phase;
        if (advance) begin
            count_nxt = (count == LAST) ? '0 : count + 1'b1;
            // Later boundaries checked first so a zero-width phase is skipped.
            if (count_nxt == '0) begin
                phase_nxt = params::ACTIVE;
            end else if (count_nxt == START_BP) begin
                phase_nxt = params::BP;
            end else if (count_nxt == START_SYNC) begin
                phase_nxt = params::SYNC;
            end else if (count_nxt == START_FP) begin
                phase_nxt = params::FP;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            count <= '0;
            phase <= params::ACTIVE;
        end else begin
            count <= count_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/video_timing.sv
// ---------------------------------------------------------------------------
// video_timing -- raster timing generator (default 640x480@60).
//
// Ports:
//   pixel_clk  in   pixel clock
//   rst        in   synchronous active-high reset
//   hpos       out  signed 12, current x (never negative)
//   vpos       out  signed 12, current y (never negative)
//   fsync      out  one-cycle pulse at hpos==0, vpos==VRES
//   hsync      out  horizontal sync, level HSYNC_POL during H sync phase
//   vsync      out  vertical sync, level VSYNC_POL during V sync lines
//   de         out  active-video enable
//   pattern    out  [7:0][0:2] BGR colour bars, only when VTIMING_PATTERN_EN
//                   is defined
//
// All outputs are registers updated on the same edge as hpos/vpos.
// ---------------------------------------------------------------------------
module video_timing #(
    parameter int unsigned HRES      = params::HRES,
    parameter int unsigned VRES      = params::VRES,
    parameter int unsigned H_FP      = params::H_FP,
    parameter int unsigned H_SYNC    = params::H_SYNC,
    parameter int unsigned H_BP      = params::H_BP,
    parameter int unsigned V_FP      = params::V_FP,
    parameter int unsigned V_SYNC    = params::V_SYNC,
    parameter int unsigned V_BP      = params::V_BP,
    parameter logic        HSYNC_POL = params::HSYNC_POL,
    parameter logic        VSYNC_POL = params::VSYNC_POL
) (
    input  logic               pixel_clk,
    input  logic               rst,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               fsync,
    output logic               hsync,
    output logic               vsync,
    output logic               de
`ifdef VTIMING_PATTERN_EN
    ,
    output logic        [7:0]  pattern [0:2]
`endif
);

    localparam int unsigned W = params::CNT_W;

    logic [W-1:0]   w_h_count;
    logic [W-1:0]   w_h_count_nxt;
    params::phase_t w_h_phase;
    params::phase_t w_h_phase_nxt;
    logic           w_h_wrap;

    logic [W-1:0]   w_v_count;
    logic [W-1:0]   w_v_count_nxt;
    params::phase_t w_v_phase;
    params::phase_t w_v_phase_nxt;
    logic           w_v_wrap;

    logic           w_de_nxt;
    logic           w_hsync_nxt;
    logic           w_vsync_nxt;
    logic           w_fsync_nxt;

    logic           r_de;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_fsync;

    vtg_axis #(
        .ACT  (HRES),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) u_h_axis (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .advance   (1'b1),
        .count     (w_h_count),
        .phase     (w_h_phase),
        .wrap      (w_h_wrap),
        .count_nxt (w_h_count_nxt),
        .phase_nxt (w_h_phase_nxt)
    );

    vtg_axis #(
        .ACT  (VRES),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) u_v_axis (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .advance   (w_h_wrap),
        .count     (w_v_count),
        .phase     (w_v_phase),
        .wrap      (w_v_wrap),
        .count_nxt (w_v_count_nxt),
        .phase_nxt (w_v_phase_nxt)
    );

    // Derived outputs are computed from the axes' next state and registered,
    // so they land on the same edge as the counts they describe.
    always_comb begin
        w_de_nxt    = (w_h_phase_nxt == params::ACTIVE) &&
                      (w_v_phase_nxt == params::ACTIVE);
        w_hsync_nxt = (w_h_phase_nxt == params::SYNC) ? HSYNC_POL : ~HSYNC_POL;
        w_vsync_nxt = (w_v_phase_nxt == params::SYNC) ? VSYNC_POL : ~VSYNC_POL;
        w_fsync_nxt = (w_h_count_nxt == '0) && (w_v_count_nxt == W'(VRES));
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_de    <= 1'b1;
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_fsync <= 1'b0;
        end else begin
            r_de    <= w_de_nxt;
            r_hsync <= w_hsync_nxt;
            r_vsync <= w_vsync_nxt;
            r_fsync <= w_fsync_nxt;
            // Registered de must agree with the phases of the current position,
            // and the frame can only wrap on a line wrap.
            assert (r_de == ((w_h_phase == params::ACTIVE) &&
                             (w_v_phase == params::ACTIVE)));
            assert (!w_v_wrap || w_h_wrap);
        end
    end

    assign hpos  = $signed(w_h_count);
    assign vpos  = $signed(w_v_count);
    assign de    = r_de;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign fsync = r_fsync;

`ifdef VTIMING_PATTERN_EN
    // Reset parks at (0,0) with de high, so the pattern shows the first bar.
    localparam logic [2:0] RESET_BGR = params::bar_bgr('0, HRES);

    logic [2:0] w_bgr_nxt;
    logic [7:0] r_pattern [0:2];

    assign w_bgr_nxt = params::bar_bgr(w_h_count_nxt, HRES);

    always_ff @(posedge pixel_clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (rst) begin
                r_pattern[i] <= RESET_BGR[i] ? 8'hFF : 8'h00;
            end else begin
                r_pattern[i] <= (w_de_nxt && w_bgr_nxt[i]) ? 8'hFF : 8'h00;
            end
        end
    end

    assign pattern = r_pattern;
`endif

endmodule
